// File: rtl/nf_gpio_in_cond_pkg.sv
// Shared GPIO settings: input-conditioner register offsets and bus decode helper.
`ifndef NF_GPIO_WIDTH
`define NF_GPIO_WIDTH 8
`endif

package nf_gpio_in_cond_pkg;

    localparam logic [3:0] NF_GPIO_IC_DEB  = 4'h0;
    localparam logic [3:0] NF_GPIO_IC_IEN  = 4'h4;
    localparam logic [3:0] NF_GPIO_IC_IST  = 4'h8;
    localparam logic [3:0] NF_GPIO_IC_SYNC = 4'hC;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_DEB,
        SEL_IEN,
        SEL_IST,
        SEL_SYNC
    } reg_sel_e;

    function automatic reg_sel_e ic_decode(input logic [3:0] off);
        case (off)
            NF_GPIO_IC_DEB:  return SEL_DEB;
            NF_GPIO_IC_IEN:  return SEL_IEN;
            NF_GPIO_IC_IST:  return SEL_IST;
            NF_GPIO_IC_SYNC: return SEL_SYNC;
            default:         return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/nf_gpio_deb_bit.sv
// One input pin: two-flop synchronizer, 2-deep tick history and 3-sample agreement filter.
module nf_gpio_deb_bit (
    input  logic clk,
    input  logic resetn,
    input  logic i_pad,
    input  logic i_tick,
    input  logic i_bypass,
    output logic o_sync,
    output logic o_gpi,
    output logic o_rise
);

    logic       r_s1;
    logic       r_s2;
    logic [1:0] r_h;
    logic       r_gpi;
    logic       w_agree;
    logic       w_gpi_nxt;

    assign w_agree = (r_s2 == r_h[0]) && (r_s2 == r_h[1]);

    always_comb begin
        // NOTE: default assigned first so no latch is inferred on the hold path.
        w_gpi_nxt = r_gpi;
        if (i_bypass) begin
            w_gpi_nxt = r_s2;
        end else if (i_tick && w_agree) begin
            w_gpi_nxt = r_s2;
        end
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_h   <= 2'b00;
            r_gpi <= 1'b0;
        end else begin
            r_s1  <= i_pad;
            r_s2  <= r_s1;
            if (i_tick) begin
                r_h <= {r_h[0], r_s2};
            end
            r_gpi <= w_gpi_nxt;
        end
    end

    assign o_sync = r_s2;
    assign o_gpi  = r_gpi;
    assign o_rise = w_gpi_nxt & ~r_gpi;

endmodule

// File: rtl/nf_gpio_in_cond.sv
// GPIO input conditioner: per-pin sync/debounce, shared prescaler, rising-edge interrupts.
module nf_gpio_in_cond
    import nf_gpio_in_cond_pkg::*;
#(
    parameter int gpio_w = `NF_GPIO_WIDTH,
    parameter int cnt_w  = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [31:0]       addr,
    input  logic              we,
    input  logic [31:0]       wd,
    output logic [31:0]       rd,
    input  logic [gpio_w-1:0] pad_i,
    output logic [gpio_w-1:0] gpi,
    output logic              irq
);

    logic [cnt_w-1:0]  r_deb;
    logic [cnt_w-1:0]  r_cnt;
    logic [gpio_w-1:0] r_ien;
    logic [gpio_w-1:0] r_ist;
    logic [gpio_w-1:0] w_sync;
    logic [gpio_w-1:0] w_rise;
    reg_sel_e          w_sel;
    logic              w_wr_deb;
    logic              w_wr_ien;
    logic              w_wr_ist;
    logic              w_bypass;
    logic              w_tick;
    logic              w_unused;

    assign w_sel    = ic_decode(addr[3:0]);
    assign w_wr_deb = we && (w_sel == SEL_DEB);
    assign w_wr_ien = we && (w_sel == SEL_IEN);
    assign w_wr_ist = we && (w_sel == SEL_IST);

    assign w_bypass = (r_deb == '0);
    assign w_tick   = !w_bypass && (r_cnt == r_deb - cnt_w'(1));

    // A set from a new rising edge is OR-ed in after the clear, so it wins a collision.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_deb <= '0;
            r_cnt <= '0;
            r_ien <= '0;
            r_ist <= '0;
        end else begin
            if (w_wr_deb) begin
                r_deb <= wd[cnt_w-1:0];
                r_cnt <= '0;
            end else if (w_tick) begin
                r_cnt <= '0;
            end else if (!w_bypass) begin
                r_cnt <= r_cnt + cnt_w'(1);
            end
            if (w_wr_ien) begin
                r_ien <= wd[gpio_w-1:0];
            end
            r_ist <= (w_wr_ist ? (r_ist & ~wd[gpio_w-1:0]) : r_ist) | (w_rise & r_ien);
        end
    end

    for (genvar g = 0; g < gpio_w; g++) begin : g_bit
        nf_gpio_deb_bit u_bit (
            .clk      (clk),
            .resetn   (resetn),
            .i_pad    (pad_i[g]),
            .i_tick   (w_tick),
            .i_bypass (w_bypass),
            .o_sync   (w_sync[g]),
            .o_gpi    (gpi[g]),
            .o_rise   (w_rise[g])
        );
    end

    always_comb begin
        rd = '0;
        case (w_sel)
            SEL_DEB:  rd = 32'(r_deb);
            SEL_IEN:  rd = 32'(r_ien);
            SEL_IST:  rd = 32'(r_ist);
            SEL_SYNC: rd = 32'(w_sync);
            default:  rd = '0;
        endcase
    end

    assign irq      = |(r_ist & r_ien);
    assign w_unused = ^{addr[31:4], wd};

endmodule

// File: tb/tb_nf_gpio_in_cond.sv
// Self-checking bench for nf_gpio_in_cond: directed scenarios plus randomized run vs a sample-history model.
module tb_nf_gpio_in_cond;

    localparam int W  = 8;
    localparam int CW = 16;

    logic          clk    = 1'b0;
    logic          resetn = 1'b0;
    logic [31:0]   addr   = '0;
    logic          we     = 1'b0;
    logic [31:0]   wd     = '0;
    logic [31:0]   rd;
    logic [W-1:0]  pad_i  = '0;
    logic [W-1:0]  gpi;
    logic          irq;

    int errors = 0;
    int checks = 0;

    nf_gpio_in_cond #(.gpio_w(W), .cnt_w(CW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .addr   (addr),
        .we     (we),
        .wd     (wd),
        .rd     (rd),
        .pad_i  (pad_i),
        .gpi    (gpi),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    // Reference model: pin values seen at each edge, samples taken at each tick, register values.
    logic [W-1:0]  m_pad_q[$];
    logic [W-1:0]  m_tick_q[$];
    logic [W-1:0]  m_gpi;
    logic [W-1:0]  m_ien;
    logic [W-1:0]  m_ist;
    logic [CW-1:0] m_deb;
    int unsigned   m_cnt;

    function automatic void model_reset();
        m_pad_q  = {};
        m_tick_q = {};
        m_tick_q.push_back('0);
        m_tick_q.push_back('0);
        m_gpi = '0;
        m_ien = '0;
        m_ist = '0;
        m_deb = '0;
        m_cnt = 0;
    endfunction

    function automatic logic [W-1:0] m_sync();
        if (m_pad_q.size() < 2) return '0;
        return m_pad_q[m_pad_q.size()-2];
    endfunction

    function automatic logic m_irq();
        return |(m_ist & m_ien);
    endfunction

    function automatic logic [31:0] m_rd(input logic [31:0] a);
        case (a[3:0])
            4'h0:    return 32'(m_deb);
            4'h4:    return 32'(m_ien);
            4'h8:    return 32'(m_ist);
            4'hC:    return 32'(m_sync());
            default: return 32'h0;
        endcase
    endfunction

    function automatic void model_edge();
        logic [W-1:0] s2, nxt, mask, a, b;
        logic [3:0]   off;
        int           p;
        s2  = m_sync();
        nxt = m_gpi;
        p   = int'(m_deb);
        off = addr[3:0];
        if (p == 0) begin
            nxt = s2;
        end else if ((m_cnt % p) == p - 1) begin
            a    = m_tick_q[m_tick_q.size()-1];
            b    = m_tick_q[m_tick_q.size()-2];
            mask = ~(s2 ^ a) & ~(s2 ^ b);
            nxt  = (m_gpi & ~mask) | (s2 & mask);
            m_tick_q.push_back(s2);
        end
        if (we && off == 4'h8) m_ist = m_ist & ~wd[W-1:0];
        m_ist = m_ist | (nxt & ~m_gpi & m_ien);
        m_gpi = nxt;
        if (we && off == 4'h4) m_ien = wd[W-1:0];
        if (we && off == 4'h0) begin
            m_deb = wd[CW-1:0];
            m_cnt = 0;
        end else if (p != 0) begin
            m_cnt++;
        end
        m_pad_q.push_back(pad_i);
        if (m_pad_q.size() > 4) void'(m_pad_q.pop_front());
        if (m_tick_q.size() > 4) void'(m_tick_q.pop_front());
    endfunction

    task automatic clk_edge();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) clk_edge();
    endtask

    task automatic bus_write(input logic [3:0] off, input logic [31:0] data);
        addr = {28'h0, off};
        wd   = data;
        we   = 1'b1;
        clk_edge();
        we   = 1'b0;
        wd   = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] data);
        addr = a;
        #1;
        data = rd;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        model_reset();
        pad_i = 8'hA5;
        @(posedge clk);
        #1;
        checks++;
        if (gpi !== '0) begin
            errors++;
            $display("FAIL reset_gpi: got %h expected 00", gpi);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b expected 0", irq);
        end
        for (int a = 0; a < 16; a += 4) begin
            bus_read(32'(a), v);
            checks++;
            if (v !== 32'h0) begin
                errors++;
                $display("FAIL reset_rd_%0h: got %h expected 00000000", a, v);
            end
        end
        pad_i = '0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_bypass();
        logic [31:0] v;
        cycles(3);
        pad_i = 8'h01;
        clk_edge();
        checks++;
        if (gpi !== 8'h00) begin
            errors++;
            $display("FAIL bypass_k: got %h expected 00", gpi);
        end
        clk_edge();
        bus_read(32'hC, v);
        checks++;
        if (v !== 32'h1) begin
            errors++;
            $display("FAIL bypass_sync_k1: got %h expected 00000001", v);
        end
        checks++;
        if (gpi !== 8'h00) begin
            errors++;
            $display("FAIL bypass_k1: got %h expected 00", gpi);
        end
        clk_edge();
        checks++;
        if (gpi !== 8'h01) begin
            errors++;
            $display("FAIL bypass_k2: got %h expected 01", gpi);
        end
        pad_i = '0;
        cycles(3);
        checks++;
        if (gpi !== 8'h00) begin
            errors++;
            $display("FAIL bypass_fall: got %h expected 00", gpi);
        end
    endtask

    task automatic test_glitch();
        logic seen_high = 1'b0;
        int   model_err = 0;
        bus_write(4'h0, 32'd4);
        for (int i = 0; i < 32; i++) begin
            pad_i = (i < 8) ? 8'h01 : 8'h00;
            clk_edge();
            if (gpi[0]) seen_high = 1'b1;
            if (gpi !== m_gpi) model_err++;
        end
        checks++;
        if (seen_high) begin
            errors++;
            $display("FAIL glitch_reject: got gpi[0] high expected low throughout");
        end
        pad_i = 8'h01;
        for (int i = 1; i <= 20; i++) begin
            clk_edge();
            if (gpi !== m_gpi) model_err++;
            if (i == 10) begin
                checks++;
                if (gpi[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL glitch_early: got %b expected 0", gpi[0]);
                end
            end
            if (i == 16) begin
                checks++;
                if (gpi[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL glitch_qualify: got %b expected 1", gpi[0]);
                end
            end
        end
        pad_i = 8'h00;
        for (int i = 0; i < 20; i++) begin
            clk_edge();
            if (gpi !== m_gpi) model_err++;
        end
        checks++;
        if (gpi !== 8'h00) begin
            errors++;
            $display("FAIL glitch_release: got %h expected 00", gpi);
        end
        checks++;
        if (model_err != 0) begin
            errors++;
            $display("FAIL glitch_model: got %0d cycle mismatches expected 0", model_err);
        end
    endtask

    task automatic test_irq();
        logic [31:0] v;
        bus_write(4'h4, 32'h3);
        pad_i = 8'h02;
        cycles(20);
        bus_read(32'h8, v);
        checks++;
        if (v !== 32'h2) begin
            errors++;
            $display("FAIL irq_status: got %h expected 00000002", v);
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set: got %b expected 1", irq);
        end
        bus_write(4'h8, 32'h2);
        bus_read(32'h8, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL irq_w1c: got %h expected 00000000", v);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_cleared: got %b expected 0", irq);
        end
        pad_i = 8'h00;
        cycles(20);
        bus_read(32'h8, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL irq_fall_no_set: got %h expected 00000000", v);
        end
    endtask

    task automatic test_collision();
        logic [31:0] v;
        bus_write(4'h0, 32'h0);
        pad_i = 8'h02;
        clk_edge();
        clk_edge();
        bus_write(4'h8, 32'h2);
        checks++;
        if (gpi !== 8'h02) begin
            errors++;
            $display("FAIL collide_gpi: got %h expected 02", gpi);
        end
        bus_read(32'h8, v);
        checks++;
        if (v !== 32'h2) begin
            errors++;
            $display("FAIL collide_set_wins: got %h expected 00000002", v);
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL collide_irq: got %b expected 1", irq);
        end
        bus_write(4'h8, 32'h2);
        pad_i = 8'h00;
        cycles(3);
    endtask

    task automatic test_mask();
        logic [31:0] v;
        bus_write(4'h4, 32'h3);
        pad_i = 8'h04;
        cycles(3);
        bus_read(32'h8, v);
        checks++;
        if (gpi !== 8'h04 || v !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL mask_disabled: got gpi=%h ist=%h irq=%b expected gpi=04 ist=0 irq=0", gpi, v, irq);
        end
        bus_write(4'h4, 32'h7);
        pad_i = 8'h00;
        cycles(3);
        bus_read(32'h8, v);
        checks++;
        if (gpi !== 8'h00 || v !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL mask_falling: got gpi=%h ist=%h irq=%b expected gpi=00 ist=0 irq=0", gpi, v, irq);
        end
        pad_i = 8'h01;
        cycles(3);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL mask_bit0_irq: got %b expected 1", irq);
        end
        bus_write(4'h4, 32'h0);
        bus_read(32'h8, v);
        checks++;
        if (irq !== 1'b0 || v !== 32'h1) begin
            errors++;
            $display("FAIL mask_en_clear: got irq=%b ist=%h expected irq=0 ist=1", irq, v);
        end
        bus_write(4'h8, 32'h1);
        pad_i = 8'h00;
        cycles(3);
    endtask

    task automatic test_random();
        logic [31:0] v, a;
        logic [W-1:0] flip;
        for (int r = 0; r < 3; r++) begin
            bus_write(4'h0, (r == 0) ? 32'h0 : 32'($urandom_range(1, 5)));
            bus_write(4'h4, $urandom);
            for (int i = 0; i < 300; i++) begin
                flip  = W'($urandom) & W'($urandom) & W'($urandom);
                pad_i = pad_i ^ flip;
                if ($urandom_range(0, 15) == 0) begin
                    addr = $urandom;
                    wd   = (addr[3:0] == 4'h0) ? 32'($urandom_range(0, 5)) : $urandom;
                    we   = 1'b1;
                end
                clk_edge();
                we = 1'b0;
                checks++;
                if (gpi !== m_gpi || irq !== m_irq()) begin
                    errors++;
                    $display("FAIL rand_out[%0d.%0d]: got gpi=%h irq=%b expected gpi=%h irq=%b",
                             r, i, gpi, irq, m_gpi, m_irq());
                end
                a = $urandom;
                bus_read(a, v);
                checks++;
                if (v !== m_rd(a)) begin
                    errors++;
                    $display("FAIL rand_rd[%0d.%0d] @%h: got %h expected %h", r, i, a, v, m_rd(a));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        bus_write(4'h0, 32'h0);
        bus_write(4'h4, 32'h1);
        bus_write(4'h8, 32'hFF);
        pad_i = 8'h00;
        cycles(3);
        pad_i = 8'h01;
        cycles(3);
        bus_write(4'h0, 32'd10);
        pad_i = 8'h00;
        cycles(5);
        bus_read(32'h8, v);
        checks++;
        if (v !== 32'h1) begin
            errors++;
            $display("FAIL rstmid_pre_status: got %h expected 00000001", v);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (gpi !== '0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_outputs: got gpi=%h irq=%b expected 00/0", gpi, irq);
        end
        for (int a = 0; a < 16; a += 4) begin
            bus_read(32'(a), v);
            checks++;
            if (v !== 32'h0) begin
                errors++;
                $display("FAIL rstmid_rd_%0h: got %h expected 00000000", a, v);
            end
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        pad_i  = 8'h01;
        clk_edge();
        clk_edge();
        checks++;
        if (gpi !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_requal_early: got %h expected 00", gpi);
        end
        clk_edge();
        checks++;
        if (gpi !== 8'h01 || gpi !== m_gpi) begin
            errors++;
            $display("FAIL rstmid_requal: got %h expected 01", gpi);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_glitch();
        test_irq();
        test_collision();
        test_mask();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no completion expected finish within bound");
        $fatal(1, "timeout");
    end

endmodule
